// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multiport register file.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    localparam int unsigned RF_DATA_W_DEF = 32;
    localparam int unsigned RF_ADDR_W_DEF = 5;
    localparam int unsigned RF_NUM_RD_DEF = 2;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic int unsigned rf_slice_w(input int unsigned num, input int unsigned w);
        return num * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-register mux and, with RF_BYPASS_EN defined,
// same-cycle write forwarding (write-before-read).
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned ADDR_W   = RF_ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = raw_data;
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
`endif
        // Zero register wins over forwarding.
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data_d = '0;
        end
    end

`ifndef RF_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-read-port register file with post-reset hardware clear.
// Define RF_BYPASS_EN for write-before-read forwarding on same-cycle address match.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned ADDR_W   = RF_ADDR_W_DEF,
    parameter int unsigned NUM_RD   = RF_NUM_RD_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  read_enabled,
    input  logic [rf_slice_w(NUM_RD, ADDR_W)-1:0] read_addr,
    input  logic                                  write_enabled,
    input  logic [ADDR_W-1:0]                     write_addr,
    input  logic [DATA_W-1:0]                     write_data,
    output logic [rf_slice_w(NUM_RD, DATA_W)-1:0] read_data,
    output logic                                  read_valid,
    output logic                                  busy
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic clearing;
    logic wr_en_eff;
    logic rd_en_eff;

    assign clearing  = (state_q == RF_CLEAR);
    assign rd_en_eff = read_enabled && !clearing;
    assign wr_en_eff = write_enabled && !clearing && !((ZERO_REG != 0) && (write_addr == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RF_CLEAR;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_eff;
            unique case (state_q)
                RF_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    // All-ones count means the last register is being cleared now.
                    if (&clr_cnt_q) begin
                        state_q <= RF_READY;
                    end
                end
                RF_READY: begin
                    state_q <= RF_READY;
                end
                default: begin
                    state_q <= RF_CLEAR;
                end
            endcase
        end
    end

    // Storage is not reset directly; the clear sequencer zeroes it after reset.
    always_ff @(posedge clock) begin
        if (clearing) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en_eff) begin
            mem_q[write_addr] <= write_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = read_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clock    (clock),
            .reset_n  (reset_n),
            .rd_en    (rd_en_eff),
            .rd_addr  (addr),
            .raw_data (mem_q[addr]),
            .wr_en    (wr_en_eff),
            .wr_addr  (write_addr),
            .wr_data  (write_data),
            .rd_data  (read_data[k*DATA_W +: DATA_W])
        );
    end

    assign read_valid = rd_valid_q;
    assign busy       = clearing;

endmodule
